// File: rtl/can_frame_rx.sv
// can_frame_rx: CAN 2.0A bit-level receiver (destuff, parse, CRC-15, ACK).
// Ports: clk, reset (sync, active-high), baud_clk (bit-sample enable), can_rx
//   (bus level, 0 = dominant) in; rx_id, rx_rtr, rx_dlc, rx_data, rx_valid,
//   rx_error, err_code, ack_drive, busy out. Macro CAN_RX_ACK_EN enables ACK drive.
module can_frame_rx #(
  parameter int IDLE_BITS = 11,
  parameter int MAX_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        baud_clk,
  input  logic        can_rx,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        rx_error,
  output logic [1:0]  err_code,
  output logic        ack_drive,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_INTEG, S_IDLE, S_ID, S_RTR, S_IDE, S_R0, S_DLC,
    S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF
  } state_t;

  localparam logic [3:0] LP_MAX  = 4'(MAX_BYTES);
  localparam logic [6:0] LP_IDLE = 7'(IDLE_BITS - 1);

  localparam logic [1:0] E_STUFF = 2'd0;
  localparam logic [1:0] E_CRC   = 2'd1;
  localparam logic [1:0] E_FORM  = 2'd2;

  state_t      r_state, w_state;
  logic [6:0]  r_cnt, w_cnt;
  logic [2:0]  r_run, w_run;
  logic        r_last, w_last;
  logic [14:0] r_crc, w_crc;
  logic        r_crc_ok, w_crc_ok;
  logic [10:0] r_id, w_id;
  logic        r_rtr, w_rtr;
  logic [3:0]  r_dlc, w_dlc;
  logic [3:0]  r_nbytes, w_nbytes;
  logic [63:0] r_data, w_data;
  logic [10:0] r_rx_id, w_rx_id;
  logic        r_rx_rtr, w_rx_rtr;
  logic [3:0]  r_rx_dlc, w_rx_dlc;
  logic [63:0] r_rx_data, w_rx_data;
  logic        r_valid, w_valid;
  logic        r_error, w_error;
  logic [1:0]  r_code, w_code;
  logic        r_ack, w_ack;
  logic        r_busy, w_busy;

  logic        w_zone;
  logic        w_err;
  logic [1:0]  w_err_code;
  logic [14:0] w_crc_step;
  logic [3:0]  w_dlc_new;
  logic [3:0]  w_n_new;
  logic        w_data_end;
  logic [5:0]  w_bit_idx;
  logic        w_ack_ok;

  function automatic logic [14:0] crc_step(
    input logic [14:0] c,
    input logic        b
  );
    logic fb;
    fb = b ^ c[14];
    return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

`ifdef CAN_RX_ACK_EN
  assign w_ack_ok = r_crc_ok;
`else
  assign w_ack_ok = 1'b0;
`endif

  // Stuffed region: every bit after SOF up to the last CRC bit.
  assign w_zone = (r_state inside
    {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC});

  assign w_crc_step = crc_step(r_crc, can_rx);
  assign w_dlc_new  = {r_dlc[2:0], can_rx};
  assign w_n_new    = r_rtr ? 4'd0 :
                      (w_dlc_new > LP_MAX) ? LP_MAX : w_dlc_new;
  assign w_data_end = (r_cnt == (7'({r_nbytes, 3'b000}) - 7'd1));
  assign w_bit_idx  = 6'(7'd63 - r_cnt);

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_run      = r_run;
    w_last     = r_last;
    w_crc      = r_crc;
    w_crc_ok   = r_crc_ok;
    w_id       = r_id;
    w_rtr      = r_rtr;
    w_dlc      = r_dlc;
    w_nbytes   = r_nbytes;
    w_data     = r_data;
    w_rx_id    = r_rx_id;
    w_rx_rtr   = r_rx_rtr;
    w_rx_dlc   = r_rx_dlc;
    w_rx_data  = r_rx_data;
    w_valid    = 1'b0;
    w_error    = 1'b0;
    w_code     = r_code;
    w_ack      = r_ack;
    w_busy     = r_busy;
    w_err      = 1'b0;
    w_err_code = E_STUFF;
    if (baud_clk) begin
      if (w_zone && r_run == 3'd5) begin
        // Stuff bit: must differ from the run, then dropped.
        if (can_rx == r_last) begin
          w_err      = 1'b1;
          w_err_code = E_STUFF;
        end else begin
          w_last = can_rx;
          w_run  = 3'd1;
        end
      end else begin
        if (w_zone) begin
          w_crc = w_crc_step;
          if (can_rx == r_last) begin
            w_run = r_run + 3'd1;
          end else begin
            w_run  = 3'd1;
            w_last = can_rx;
          end
        end
        unique case (r_state)
          S_INTEG: begin
            if (!can_rx) begin
              w_cnt = 7'd0;
            end else if (r_cnt == LP_IDLE) begin
              w_state = S_IDLE;
              w_cnt   = 7'd0;
            end else begin
              w_cnt = r_cnt + 7'd1;
            end
          end
          S_IDLE: begin
            if (!can_rx) begin
              w_state = S_ID;
              w_cnt   = 7'd0;
              w_busy  = 1'b1;
              w_crc   = 15'd0;
              w_run   = 3'd1;
              w_last  = 1'b0;
              w_data  = 64'd0;
            end
          end
          S_ID: begin
            w_id = {r_id[9:0], can_rx};
            if (r_cnt == 7'd10) begin
              w_state = S_RTR;
              w_cnt   = 7'd0;
            end else begin
              w_cnt = r_cnt + 7'd1;
            end
          end
          S_RTR: begin
            w_rtr   = can_rx;
            w_state = S_IDE;
          end
          S_IDE: begin
            if (can_rx) begin
              w_err      = 1'b1;
              w_err_code = E_FORM;
            end else begin
              w_state = S_R0;
            end
          end
          S_R0: begin
            w_state = S_DLC;
            w_cnt   = 7'd0;
          end
          S_DLC: begin
            w_dlc = w_dlc_new;
            if (r_cnt == 7'd3) begin
              w_nbytes = w_n_new;
              w_cnt    = 7'd0;
              w_state  = (w_n_new == 4'd0) ? S_CRC : S_DATA;
            end else begin
              w_cnt = r_cnt + 7'd1;
            end
          end
          S_DATA: begin
            w_data[w_bit_idx] = can_rx;
            if (w_data_end) begin
              w_state = S_CRC;
              w_cnt   = 7'd0;
            end else begin
              w_cnt = r_cnt + 7'd1;
            end
          end
          S_CRC: begin
            if (r_cnt == 7'd14) begin
              w_crc_ok = (w_crc_step == 15'd0);
              w_state  = S_CRC_DEL;
              w_cnt    = 7'd0;
            end else begin
              w_cnt = r_cnt + 7'd1;
            end
          end
          S_CRC_DEL: begin
            if (!can_rx) begin
              w_err      = 1'b1;
              w_err_code = E_FORM;
            end else begin
              w_state = S_ACK;
              w_ack   = w_ack_ok;
            end
          end
          S_ACK: begin
            w_ack   = 1'b0;
            w_state = S_ACK_DEL;
          end
          S_ACK_DEL: begin
            if (!r_crc_ok) begin
              w_err      = 1'b1;
              w_err_code = E_CRC;
            end else if (!can_rx) begin
              w_err      = 1'b1;
              w_err_code = E_FORM;
            end else begin
              w_state = S_EOF;
              w_cnt   = 7'd0;
            end
          end
          S_EOF: begin
            if (!can_rx) begin
              w_err      = 1'b1;
              w_err_code = E_FORM;
            end else if (r_cnt == 7'd6) begin
              w_rx_id   = r_id;
              w_rx_rtr  = r_rtr;
              w_rx_dlc  = r_dlc;
              w_rx_data = r_data;
              w_valid   = 1'b1;
              w_busy    = 1'b0;
              w_state   = S_IDLE;
              w_cnt     = 7'd0;
            end else begin
              w_cnt = r_cnt + 7'd1;
            end
          end
          default: begin
            w_state = S_INTEG;
            w_cnt   = 7'd0;
          end
        endcase
      end
      if (w_err) begin
        w_state = S_INTEG;
        w_cnt   = 7'd0;
        w_error = 1'b1;
        w_code  = w_err_code;
        w_busy  = 1'b0;
        w_ack   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_INTEG;
      r_cnt     <= 7'd0;
      r_run     <= 3'd0;
      r_last    <= 1'b0;
      r_crc     <= 15'd0;
      r_crc_ok  <= 1'b0;
      r_id      <= 11'd0;
      r_rtr     <= 1'b0;
      r_dlc     <= 4'd0;
      r_nbytes  <= 4'd0;
      r_data    <= 64'd0;
      r_rx_id   <= 11'd0;
      r_rx_rtr  <= 1'b0;
      r_rx_dlc  <= 4'd0;
      r_rx_data <= 64'd0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_code    <= 2'd0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_run     <= w_run;
      r_last    <= w_last;
      r_crc     <= w_crc;
      r_crc_ok  <= w_crc_ok;
      r_id      <= w_id;
      r_rtr     <= w_rtr;
      r_dlc     <= w_dlc;
      r_nbytes  <= w_nbytes;
      r_data    <= w_data;
      r_rx_id   <= w_rx_id;
      r_rx_rtr  <= w_rx_rtr;
      r_rx_dlc  <= w_rx_dlc;
      r_rx_data <= w_rx_data;
      r_valid   <= w_valid;
      r_error   <= w_error;
      r_code    <= w_code;
      r_ack     <= w_ack;
      r_busy    <= w_busy;
    end
  end

  assign rx_id     = r_rx_id;
  assign rx_rtr    = r_rx_rtr;
  assign rx_dlc    = r_rx_dlc;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_valid;
  assign rx_error  = r_error;
  assign err_code  = r_code;
  assign ack_drive = r_ack;
  assign busy      = r_busy;

endmodule

// File: tb/tb_can_frame_rx.sv
// tb_can_frame_rx: directed frames into can_frame_rx.
// Frames are built bit by bit (CRC + stuffing) and driven one bit per 4 clks.
module tb_can_frame_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        baud_clk;
  logic        can_rx;
  logic [10:0] rx_id;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic [1:0]  err_code;
  logic        ack_drive;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  int n_valid = 0;
  int n_err   = 0;
  int n_ack   = 0;
  int n_both  = 0;
  int err_pos = -1;
  int cur_bit = -1;

  int v0, e0, a0;

  bit fb[$];
  int stuffed_len;

`ifdef CAN_RX_ACK_EN
  localparam int ACK_CLKS = 4;
`else
  localparam int ACK_CLKS = 0;
`endif

  always #5 clk = ~clk;

  can_frame_rx dut (
    .clk       (clk),
    .reset     (reset),
    .baud_clk  (baud_clk),
    .can_rx    (can_rx),
    .rx_id     (rx_id),
    .rx_rtr    (rx_rtr),
    .rx_dlc    (rx_dlc),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .err_code  (err_code),
    .ack_drive (ack_drive),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (rx_error) begin
      n_err++;
      err_pos = cur_bit;
    end
    if (ack_drive) n_ack++;
    if (rx_valid && rx_error) n_both++;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] crc15(
    input logic [14:0] c,
    input bit          b
  );
    return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
  endfunction

  task automatic build(
    input logic [10:0] id,
    input logic        rtr,
    input logic        ide,
    input logic [3:0]  dlc,
    input logic [63:0] data,
    input bit          flip_crc,
    input bit          bad_stuff,
    input int          eof_dom
  );
    bit          raw[$];
    logic [14:0] crc;
    int          n;
    int          run;
    bit          last;
    bit          first;
    bit          s;
    raw.delete();
    fb.delete();
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(ide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < n * 8; i++) raw.push_back(data[63 - i]);
    crc = 15'd0;
    foreach (raw[i]) crc = crc15(crc, raw[i]);
    if (flip_crc) crc[0] = ~crc[0];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    run   = 0;
    last  = 1'b0;
    first = 1'b1;
    foreach (raw[i]) begin
      if (run == 5) begin
        s = (bad_stuff && first) ? last : ~last;
        fb.push_back(s);
        first = 1'b0;
        last  = s;
        run   = 1;
      end
      fb.push_back(raw[i]);
      if (run > 0 && raw[i] == last) begin
        run++;
      end else begin
        run  = 1;
        last = raw[i];
      end
    end
    stuffed_len = fb.size();
    fb.push_back(1'b1);
    fb.push_back(1'b1);
    fb.push_back(1'b1);
    for (int i = 0; i < 7; i++) fb.push_back(i == eof_dom ? 1'b0 : 1'b1);
    for (int i = 0; i < 3; i++) fb.push_back(1'b1);
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    can_rx   = b;
    baud_clk = 1'b1;
    @(negedge clk);
    baud_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input int max);
    for (int i = 0; i < fb.size() && i < max; i++) begin
      cur_bit = i;
      send_bit(fb[i]);
    end
    cur_bit = -1;
  endtask

  task automatic idle(input int n);
    cur_bit = -1;
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic snap;
    v0 = n_valid;
    e0 = n_err;
    a0 = n_ack;
  endtask

  initial begin
    reset    = 1'b1;
    baud_clk = 1'b0;
    can_rx   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {rx_id, rx_rtr, rx_dlc, rx_valid, rx_error,
                    err_code, ack_drive, busy}, 64'd0);
    chk("rst_data", rx_data, 64'd0);
    reset = 1'b0;

    // 1: basic frame
    idle(12);
    snap();
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 0, 0, -1);
    send(1000);
    chk("t1_valid", n_valid - v0, 1);
    chk("t1_err", n_err - e0, 0);
    chk("t1_id", rx_id, 11'h123);
    chk("t1_rtr", rx_rtr, 0);
    chk("t1_dlc", rx_dlc, 2);
    chk("t1_data", rx_data, 64'hA55A_0000_0000_0000);
    chk("t1_ack", n_ack - a0, ACK_CLKS);
    chk("t1_busy", busy, 0);

    // 2: heavy stuffing, then a stuff violation
    snap();
    build(11'h000, 1'b0, 1'b0, 4'd0, 64'd0, 0, 0, -1);
    send(1000);
    chk("t2_valid", n_valid - v0, 1);
    chk("t2_id", rx_id, 11'h000);
    chk("t2_dlc", rx_dlc, 0);
    chk("t2_data", rx_data, 64'd0);
    snap();
    build(11'h000, 1'b0, 1'b0, 4'd0, 64'd0, 0, 1, -1);
    send(1000);
    chk("t2s_err", n_err - e0, 1);
    chk("t2s_valid", n_valid - v0, 0);
    chk("t2s_code", err_code, 0);
    chk("t2s_pos", err_pos, 5);

    // 3: CRC error
    idle(12);
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 0, 0, -1);
    send(1000);
    snap();
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1, 0, -1);
    send(1000);
    chk("t3_err", n_err - e0, 1);
    chk("t3_valid", n_valid - v0, 0);
    chk("t3_code", err_code, 1);
    chk("t3_pos", err_pos, stuffed_len + 2);
    chk("t3_ack", n_ack - a0, 0);
    chk("t3_data", rx_data, 64'hA55A_0000_0000_0000);

    // 4: form errors, then reintegration
    idle(12);
    snap();
    build(11'h2F0, 1'b0, 1'b1, 4'd1, 64'h7700_0000_0000_0000, 0, 0, -1);
    send(1000);
    chk("t4i_err", n_err - e0, 1);
    chk("t4i_code", err_code, 2);
    idle(12);
    snap();
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 0, 0, 3);
    send(1000);
    chk("t4e_err", n_err - e0, 1);
    chk("t4e_valid", n_valid - v0, 0);
    chk("t4e_code", err_code, 2);
    chk("t4e_pos", err_pos, stuffed_len + 6);
    snap();
    build(11'h7A5, 1'b0, 1'b0, 4'd1, 64'h3300_0000_0000_0000, 0, 0, -1);
    send(1000);
    chk("t4g_valid", n_valid - v0, 0);
    chk("t4g_err", n_err - e0, 0);
    chk("t4g_id", rx_id, 11'h123);
    idle(12);
    snap();
    send(1000);
    chk("t4r_valid", n_valid - v0, 1);
    chk("t4r_id", rx_id, 11'h7A5);
    chk("t4r_data", rx_data, 64'h3300_0000_0000_0000);

    // 5: DLC clamp
    snap();
    build(11'h555, 1'b0, 1'b0, 4'd15, 64'h0102_0304_0506_0708, 0, 0, -1);
    send(1000);
    chk("t5_valid", n_valid - v0, 1);
    chk("t5_id", rx_id, 11'h555);
    chk("t5_dlc", rx_dlc, 15);
    chk("t5_data", rx_data, 64'h0102_0304_0506_0708);
    chk("t5_ack", n_ack - a0, ACK_CLKS);

    // 6: reset mid-DATA
    idle(12);
    snap();
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 0, 0, -1);
    send(30);
    chk("t6_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ctl", {rx_id, rx_rtr, rx_dlc, rx_valid, rx_error,
                   err_code, ack_drive, busy}, 64'd0);
    chk("t6_data", rx_data, 64'd0);
    chk("t6_valid", n_valid - v0, 0);
    chk("t6_err", n_err - e0, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    chk("both_pulse", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
